// File: rtl/adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// adc_scan_ctrl
//
// Round-robin scan controller for an 8-channel, 10-bit SPI ADC. It generates
// AD_CLK and the CS frame, sends the single-ended command (start, SGL, D2..D0),
// shifts in the 10-bit result, and presents each result as a tagged one-cycle
// strobe. Only the channels enabled in ch_enable are visited, in rotation.
//
// Parameters
//   CLK_DIV  : clk cycles per AD_CLK half-period (>= 2)
//   GAP_HALF : CS-high idle between frames, in half-periods (>= 1)
//
// Ports
//   clk, rst_n    : system clock, asynchronous active-low reset
//   scan_en       : keep scanning while high (sampled in IDLE and at gap end)
//   ch_enable     : per-channel enable mask
//   AD_CLK/CS/DIN : registered SPI outputs to the ADC (AD_CLK idles low)
//   DOUT          : serial data from the ADC
//   busy          : high from CS fall until the end of the inter-frame gap
//   result_valid  : one-cycle strobe; result_ch/result_data hold until next
//   rd_ch/rd_data : result bank read port (ADC_RESULT_BANK_EN only)
//
// Optional feature: define ADC_RESULT_BANK_EN to add an 8x10-bit bank of the
// latest result per channel with a combinational read port.
// -----------------------------------------------------------------------------
module adc_scan_ctrl #(
    parameter int CLK_DIV  = 27,
    parameter int GAP_HALF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [7:0] ch_enable,
    output logic       AD_CLK,
    output logic       CS,
    output logic       DIN,
    input  logic       DOUT,
    output logic       busy,
    output logic       result_valid,
    output logic [2:0] result_ch,
    output logic [9:0] result_data
`ifdef ADC_RESULT_BANK_EN
    ,
    input  logic [2:0] rd_ch,
    output logic [9:0] rd_data
`endif
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int HW = $clog2(36 + GAP_HALF);

    localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);

    // Half-period index within a frame, counted from the CS fall (index 0).
    // Odd indices start with a rising AD_CLK edge, even ones with a falling.
    localparam logic [HW-1:0] H_FIRST_DATA = HW'(15);            // rising edge 8
    localparam logic [HW-1:0] H_LAST_FALL  = HW'(34);            // falling edge 17
    localparam logic [HW-1:0] H_GAP_END    = HW'(35 + GAP_HALF);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_div_cnt;
    logic [HW-1:0] r_half;
    logic [2:0]    r_cur_ch;
    logic [2:0]    r_last_ch;
    logic [9:0]    r_shift;
    logic          r_sclk;
    logic          r_cs;
    logic          r_din;
    logic          r_busy;
    logic          r_valid;
    logic [2:0]    r_result_ch;
    logic [9:0]    r_result_data;

    logic          w_tick;
    logic          w_start;
    logic [HW-1:0] w_half_next;
    logic [2:0]    w_next_ch;

    assign w_tick      = (r_div_cnt == '0);
    assign w_start     = scan_en && (ch_enable != 8'h00);
    assign w_half_next = r_half + 1'b1;

    // First enabled channel strictly after r_last_ch, wrapping 7 -> 0; an
    // offset of 8 lands back on r_last_ch, so a lone channel repeats.
    // Scanning offsets downward lets the smallest offset win.
    // NOTE: combinational blocks assign a default first so that no path
    // leaves the output unassigned, which would infer a latch.
    always_comb begin
        w_next_ch = r_last_ch;
        for (int i = 8; i >= 1; i--) begin
            if (ch_enable[3'(int'(r_last_ch) + i)]) begin
                w_next_ch = 3'(int'(r_last_ch) + i);
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_div_cnt     <= '0;
            r_half        <= '0;
            r_cur_ch      <= 3'd0;
            r_last_ch     <= 3'd7;
            r_shift       <= '0;
            r_sclk        <= 1'b0;
            r_cs          <= 1'b1;
            r_din         <= 1'b0;
            r_busy        <= 1'b0;
            r_valid       <= 1'b0;
            r_result_ch   <= 3'd0;
            r_result_data <= '0;
        end else begin
            r_valid <= 1'b0;

            // Half-period timer: free-running while a frame or gap is active.
            if (r_state != S_IDLE) begin
                r_div_cnt <= w_tick ? DIV_M1 : r_div_cnt - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cs      <= 1'b0;
                        r_din     <= 1'b1;          // start bit on CS fall
                        r_busy    <= 1'b1;
                        r_cur_ch  <= w_next_ch;
                        r_half    <= '0;
                        r_div_cnt <= DIV_M1;
                        r_state   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_tick) begin
                        r_sclk  <= 1'b1;            // rising edge 1
                        r_half  <= w_half_next;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (w_tick) begin
                        r_half <= w_half_next;
                        if (w_half_next[0]) begin
                            r_sclk <= 1'b1;
                            // Rising edges 8..17 carry B9..B0.
                            if (w_half_next >= H_FIRST_DATA) begin
                                r_shift <= {r_shift[8:0], DOUT};
                            end
                        end else begin
                            r_sclk <= 1'b0;
                            // Falling edges 1..4 present SGL, D2, D1, D0.
                            case (w_half_next)
                                HW'(2):  r_din <= 1'b1;
                                HW'(4):  r_din <= r_cur_ch[2];
                                HW'(6):  r_din <= r_cur_ch[1];
                                HW'(8):  r_din <= r_cur_ch[0];
                                default: r_din <= 1'b0;
                            endcase
                            if (w_half_next == H_LAST_FALL) begin
                                r_state <= S_HOLD;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (w_tick) begin
                        r_cs          <= 1'b1;
                        r_valid       <= 1'b1;
                        r_result_ch   <= r_cur_ch;
                        r_result_data <= r_shift;
                        r_last_ch     <= r_cur_ch;
                        r_half        <= w_half_next;
                        r_state       <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (w_tick) begin
                        if (w_half_next == H_GAP_END) begin
                            if (w_start) begin
                                r_cs     <= 1'b0;
                                r_din    <= 1'b1;
                                r_cur_ch <= w_next_ch;
                                r_half   <= '0;
                                r_state  <= S_SETUP;
                            end else begin
                                r_busy   <= 1'b0;
                                r_state  <= S_IDLE;
                            end
                        end else begin
                            r_half <= w_half_next;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign AD_CLK       = r_sclk;
    assign CS           = r_cs;
    assign DIN          = r_din;
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign result_ch    = r_result_ch;
    assign result_data  = r_result_data;

`ifdef ADC_RESULT_BANK_EN
    logic [9:0] r_bank [8];

    // NOTE: the bank is small and must read as zero after reset, so it is
    // built from flops with an explicit clear rather than as a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_bank[i] <= '0;
            end
        end else if (r_state == S_HOLD && w_tick) begin
            r_bank[r_cur_ch] <= r_shift;
        end
    end

    assign rd_data = r_bank[rd_ch];
`endif

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_ctrl
//
// Bench for adc_scan_ctrl with CLK_DIV=4, GAP_HALF=2. An ADC model decodes
// the command and returns 10'h2A5 for channel 2 and 10'h100+ch otherwise.
// A frame-phase model predicts every output on every cycle; directed
// scenarios pin timing, ordering and reset behaviour with literal values,
// followed by a randomized scan_en/ch_enable/reset run.
// -----------------------------------------------------------------------------
module tb_adc_scan_ctrl;

    localparam int D = 4;
    localparam int G = 2;

    logic       clk;
    logic       rst_n;
    logic       scan_en;
    logic [7:0] ch_enable;
    logic       AD_CLK;
    logic       CS;
    logic       DIN;
    logic       DOUT;
    logic       busy;
    logic       result_valid;
    logic [2:0] result_ch;
    logic [9:0] result_data;
`ifdef ADC_RESULT_BANK_EN
    logic [2:0] rd_ch;
    logic [9:0] rd_data;
`endif

    adc_scan_ctrl #(.CLK_DIV(D), .GAP_HALF(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_en      (scan_en),
        .ch_enable    (ch_enable),
        .AD_CLK       (AD_CLK),
        .CS           (CS),
        .DIN          (DIN),
        .DOUT         (DOUT),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .result_data  (result_data)
`ifdef ADC_RESULT_BANK_EN
        ,
        .rd_ch        (rd_ch),
        .rd_data      (rd_data)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [9:0] adc_val(input logic [2:0] ch);
        return (ch == 3'd2) ? 10'h2A5 : 10'h100 + 10'(ch);
    endfunction

    function automatic logic [2:0] next_ch(input logic [2:0] last, input logic [7:0] en);
        for (int i = 1; i <= 8; i++) begin
            int c;
            c = (int'(last) + i) % 8;
            if (en[c]) return 3'(c);
        end
        return last;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- ADC model ----------------
    int         adc_edges = 0;
    logic [4:0] adc_cmd   = '0;
    logic [4:0] last_cmd  = '0;

    initial begin
        logic prev_cs, prev_sclk;
        logic [9:0] v;
        prev_cs   = 1'b1;
        prev_sclk = 1'b0;
        DOUT      = 1'b0;
        forever begin
            @(CS or AD_CLK);
            if (prev_cs && !CS) begin
                adc_edges = 0;
                adc_cmd   = '0;
                DOUT      = 1'b0;
            end
            if (!CS && !prev_sclk && AD_CLK) begin
                adc_edges++;
                if (adc_edges <= 5) adc_cmd = {adc_cmd[3:0], DIN};
                if (adc_edges == 5) last_cmd = adc_cmd;
            end
            if (!CS && prev_sclk && !AD_CLK) begin
                // After falling edge k, present the bit sampled at rising k+1.
                v = adc_val(adc_cmd[2:0]);
                if (adc_edges >= 7 && adc_edges <= 16) DOUT = v[16 - adc_edges];
                else DOUT = 1'b0;
            end
            prev_cs   = CS;
            prev_sclk = AD_CLK;
        end
    end

    // ---------------- frame-phase reference model ----------------
    // m_p counts clk cycles since the CS fall of the frame in flight.
    logic       m_active;
    int         m_p;
    logic [2:0] m_ch;
    logic [2:0] m_last;
    logic [2:0] m_rch;
    logic [9:0] m_rdata;

    initial begin
        m_active = 1'b0; m_p = 0; m_ch = 3'd0; m_last = 3'd7; m_rch = 3'd0; m_rdata = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0; m_p = 0; m_ch = 3'd0; m_last = 3'd7; m_rch = 3'd0; m_rdata = '0;
            end else if (m_active) begin
                m_p++;
                if (m_p == 35 * D) begin
                    m_rch   = m_ch;
                    m_rdata = adc_val(m_ch);
                    m_last  = m_ch;
                end
                if (m_p == (35 + G) * D) begin
                    m_p = 0;
                    if (scan_en && ch_enable != 8'h00) m_ch = next_ch(m_last, ch_enable);
                    else m_active = 1'b0;
                end
            end else if (scan_en && ch_enable != 8'h00) begin
                m_active = 1'b1;
                m_p      = 0;
                m_ch     = next_ch(m_last, ch_enable);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        int   n;
        logic e_cs, e_sclk, e_din, e_rv;
        logic [4:0] bits;
        forever begin
            @(negedge clk);
            n    = m_p / D;
            bits = {1'b1, 1'b1, m_ch};
            e_cs   = !(m_active && m_p < 35 * D);
            e_sclk = m_active && m_p >= D && m_p < 34 * D && (n % 2 == 1);
            e_din  = m_active && n < 10 && bits[4 - n / 2];
            e_rv   = m_active && m_p == 35 * D;
            check("cs",           CS,           e_cs);
            check("ad_clk",       AD_CLK,       e_sclk);
            check("din",          DIN,          e_din);
            check("busy",         busy,         m_active);
            check("result_valid", result_valid, e_rv);
            check("result_ch",    result_ch,    m_rch);
            check("result_data",  result_data,  m_rdata);
        end
    end

    // ---------------- event monitor ----------------
    int         cs_falls = 0, cs_fall_cyc = 0, rise_in_frame = 0, sclk_rises = 0;
    int         busy_falls = 0, busy_fall_cyc = 0;
    int         sq_cyc[$];
    logic [2:0] sq_ch[$];
    logic [9:0] sq_data[$];

    initial begin
        logic pcs, psclk, pbusy;
        pcs = 1'b1; psclk = 1'b0; pbusy = 1'b0;
        forever begin
            @(negedge clk);
            if (pcs && !CS) begin
                cs_falls++;
                cs_fall_cyc   = cyc;
                rise_in_frame = 0;
            end
            if (!psclk && AD_CLK) begin
                sclk_rises++;
                rise_in_frame++;
            end
            if (result_valid) begin
                sq_cyc.push_back(cyc);
                sq_ch.push_back(result_ch);
                sq_data.push_back(result_data);
            end
            if (pbusy && !busy) begin
                busy_falls++;
                busy_fall_cyc = cyc;
            end
            pcs = CS; psclk = AD_CLK; pbusy = busy;
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_strobes(input int n, input int budget);
        int t = 0;
        while (sq_ch.size() < n && t < budget) begin @(negedge clk); t++; end
        check("wait_strobe", 32'(sq_ch.size() >= n), 32'd1);
    endtask

    task automatic wait_cs_fall(input int c0, input int budget);
        int t = 0;
        while (cs_falls <= c0 && t < budget) begin @(negedge clk); t++; end
        check("wait_cs_fall", 32'(cs_falls > c0), 32'd1);
    endtask

    task automatic wait_rise(input int k, input int budget);
        int t = 0;
        while (rise_in_frame < k && t < budget) begin @(negedge clk); t++; end
        check("wait_rise", 32'(rise_in_frame >= k), 32'd1);
    endtask

    task automatic wait_busy_fall(input int b0, input int budget);
        int t = 0;
        while (busy_falls <= b0 && t < budget) begin @(negedge clk); t++; end
        check("wait_busy_fall", 32'(busy_falls > b0), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int s0, s1, c0, b0, r0, rel;
        rst_n = 1'b0; scan_en = 1'b0; ch_enable = 8'h00;
`ifdef ADC_RESULT_BANK_EN
        rd_ch = 3'd0;
`endif
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        // Reset with no activity.
        r0 = sclk_rises;
        repeat (1000) @(negedge clk);
        check("idle_sclk_rises", sclk_rises - r0, 0);
        check("idle_cs", CS, 1'b1);
        check("idle_sclk", AD_CLK, 1'b0);
        check("idle_din", DIN, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_rv", result_valid, 1'b0);

        // Single frame on channel 2 from a scan_en pulse.
        ch_enable = 8'h04;
        c0 = cs_falls;
        s0 = sq_ch.size();
        scan_en = 1'b1;
        @(negedge clk);
        scan_en = 1'b0;
        wait_strobes(s0 + 1, 400);
        check("t1_latency", sq_cyc[s0] - cs_fall_cyc, 140);
        check("t1_ch", sq_ch[s0], 3'd2);
        check("t1_data", sq_data[s0], 10'h2A5);
        check("t1_din_cmd", last_cmd, 5'b11010);
        repeat (300) @(negedge clk);
        check("t1_one_frame", cs_falls - c0, 1);
        check("t1_idle_cs", CS, 1'b1);
        check("t1_idle_busy", busy, 1'b0);

        // Continuous scan of channels 0, 1, 7.
        do_reset();
        s0 = sq_ch.size();
        ch_enable = 8'b1000_0011;
        scan_en = 1'b1;
        wait_strobes(s0 + 4, 800);
        check("t2_ch0", sq_ch[s0],     3'd0);
        check("t2_ch1", sq_ch[s0 + 1], 3'd1);
        check("t2_ch2", sq_ch[s0 + 2], 3'd7);
        check("t2_ch3", sq_ch[s0 + 3], 3'd0);
        for (int i = 0; i < 3; i++) check("t2_spacing", sq_cyc[s0 + i + 1] - sq_cyc[s0 + i], 148);

        // scan_en dropped at rising edge 9 of the next (channel 1) frame.
        c0 = cs_falls;
        wait_cs_fall(c0, 100);
        wait_rise(9, 100);
        scan_en = 1'b0;
        s0 = sq_ch.size();
        b0 = busy_falls;
        wait_strobes(s0 + 1, 200);
        check("t3_ch", sq_ch[s0], 3'd1);
        check("t3_data", sq_data[s0], 10'h101);
        wait_busy_fall(b0, 50);
        check("t3_busy_fall", busy_fall_cyc - sq_cyc[s0], 8);
        repeat (400) @(negedge clk);
        check("t3_no_more_frames", cs_falls - c0, 1);

        // Reset at rising edge 12 of a channel-2 frame.
        do_reset();
        s0 = sq_ch.size();
        ch_enable = 8'h06;
        scan_en = 1'b1;
        wait_strobes(s0 + 1, 200);
        check("t4_first_ch", sq_ch[s0], 3'd1);
        c0 = cs_falls;
        wait_cs_fall(c0, 100);
        wait_rise(12, 100);
        #1 rst_n = 1'b0;
        #1;
        check("t4_async_cs", CS, 1'b1);
        check("t4_async_sclk", AD_CLK, 1'b0);
        s1 = sq_ch.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        wait_strobes(s1 + 1, 300);
        check("t4_restart_ch", sq_ch[s1], 3'd1);
        check("t4_restart_latency", sq_cyc[s1] - rel, 141);

        // Randomized enable/mask/reset activity against the model.
        ch_enable = 8'($urandom);
        scan_en = 1'b1;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) scan_en = ~scan_en;
            if ($urandom_range(0, 299) == 0)
                ch_enable = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3999) == 0) begin
                #1 rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        end
        scan_en = 1'b0;

`ifdef ADC_RESULT_BANK_EN
        // One full scan of all channels fills the bank.
        do_reset();
        s0 = sq_ch.size();
        ch_enable = 8'hFF;
        scan_en = 1'b1;
        wait_strobes(s0 + 8, 1400);
        scan_en = 1'b0;
        rd_ch = 3'd2; #1 check("bank_ch2", rd_data, 10'h2A5);
        rd_ch = 3'd5; #1 check("bank_ch5", rd_data, 10'h105);
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1 check("bank_all", rd_data, adc_val(3'(i)));
        end
`endif

        repeat (200) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
